// File: rtl/eclair_mul_pipe.sv
// eclair_mul_pipe: pipelined multiplier with per-operand signedness, valid/ready flow
// control (whole-pipe stall) and a shift/round/saturate output stage.

module eclair_mul_pipe_chk #(
   parameter int DOUT_WIDTH = 26,
   parameter int SATURATE   = 0
) (
   input logic                  ap_clk,
   input logic                  ap_rst_n,
   input logic                  in_ready,
   input logic                  out_valid,
   input logic                  out_ready,
   input logic [DOUT_WIDTH-1:0] dout,
   input logic                  dout_sat
);
   a_hold: assert property (@(posedge ap_clk)
      (ap_rst_n && out_valid && !out_ready) |=>
      (!ap_rst_n || (out_valid && $stable(dout) && $stable(dout_sat))));

   a_ready: assert property (@(posedge ap_clk) in_ready == !(out_valid && !out_ready));

   a_nosat: assert property (@(posedge ap_clk) (SATURATE != 0) || !dout_sat);
endmodule

module eclair_mul_pipe #(
   parameter int NUM_STAGE   = 2,
   parameter int DIN0_WIDTH  = 10,
   parameter int DIN1_WIDTH  = 16,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 1,
   parameter int DOUT_WIDTH  = 26,
   parameter int SHIFT       = 0,
   parameter int ROUND       = 0,
   parameter int SATURATE    = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_sat
);
   // One spare bit above the true product width keeps the rounding add from overflowing.
   localparam int PW   = DIN0_WIDTH + DIN1_WIDTH + 2;
   localparam int CW   = ((PW > DOUT_WIDTH) ? PW : DOUT_WIDTH) + 1;
   localparam int NR   = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
   localparam int SHM1 = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [PW-1:0] RND_C =
      ((ROUND != 0) && (SHIFT > 0)) ? (PW'(1'b1) << SHM1) : {PW{1'b0}};
   localparam logic signed [CW-1:0] SAT_MAX =
      {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [CW-1:0] SAT_MIN =
      {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   generate
      if ((NUM_STAGE < 1) || (NUM_STAGE > 4) || (SHIFT < 0) ||
          (SHIFT >= DIN0_WIDTH + DIN1_WIDTH)) begin : g_bad_param
         $error("eclair_mul_pipe: illegal NUM_STAGE or SHIFT");
      end
   endgenerate

   logic                   stall_s;
   logic [DIN0_WIDTH-1:0]  a_src_s;
   logic [DIN1_WIDTH-1:0]  b_src_s;
   logic                   v_src_s;
   logic signed [PW-1:0]   a_ext_s;
   logic signed [PW-1:0]   b_ext_s;
   logic signed [PW-1:0]   p_s;
   logic signed [PW-1:0]   q_s;
   logic signed [CW-1:0]   q_ext_s;
   logic [DOUT_WIDTH-1:0]  res_d;
   logic                   sat_d;
   logic [DOUT_WIDTH-1:0]  res_q [NR];
   logic                   sat_q [NR];
   logic                   vld_q [NR];

   assign stall_s  = out_valid & ~out_ready;
   assign in_ready = ~stall_s;

   generate
      if (NUM_STAGE > 1) begin : g_opreg
         logic [DIN0_WIDTH-1:0] a_q;
         logic [DIN1_WIDTH-1:0] b_q;
         logic                  v_op_q;

         // Operand capture stage; arithmetic happens between this and the result stage.
         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               v_op_q <= 1'b0;
               a_q    <= {DIN0_WIDTH{1'b0}};
               b_q    <= {DIN1_WIDTH{1'b0}};
            end else if (!stall_s) begin
               v_op_q <= in_valid;
               if (in_valid) begin
                  a_q <= din0;
                  b_q <= din1;
               end
            end
         end

         assign a_src_s = a_q;
         assign b_src_s = b_q;
         assign v_src_s = v_op_q;
      end else begin : g_nooprg
         assign a_src_s = din0;
         assign b_src_s = din1;
         assign v_src_s = in_valid;
      end
   endgenerate

   // Full signed product, rounding shift, then clamp or wrap to the output width.
   always_comb begin
      a_ext_s = {{(PW-DIN0_WIDTH){(DIN0_SIGNED != 0) ? a_src_s[DIN0_WIDTH-1] : 1'b0}}, a_src_s};
      b_ext_s = {{(PW-DIN1_WIDTH){(DIN1_SIGNED != 0) ? b_src_s[DIN1_WIDTH-1] : 1'b0}}, b_src_s};
      p_s     = a_ext_s * b_ext_s;
      q_s     = (p_s + $signed(RND_C)) >>> SHIFT;
      q_ext_s = {{(CW-PW){q_s[PW-1]}}, q_s};
      res_d   = {DOUT_WIDTH{1'b0}};
      sat_d   = 1'b0;
      if ((SATURATE != 0) && (q_ext_s > SAT_MAX)) begin
         res_d = SAT_MAX[DOUT_WIDTH-1:0];
         sat_d = 1'b1;
      end else if ((SATURATE != 0) && (q_ext_s < SAT_MIN)) begin
         res_d = SAT_MIN[DOUT_WIDTH-1:0];
         sat_d = 1'b1;
      end else begin
         res_d = q_ext_s[DOUT_WIDTH-1:0];
         sat_d = 1'b0;
      end
   end

   // Result stages; the last one drives the outputs directly.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NR; i++) begin
            vld_q[i] <= 1'b0;
            res_q[i] <= {DOUT_WIDTH{1'b0}};
            sat_q[i] <= 1'b0;
         end
      end else if (!stall_s) begin
         vld_q[0] <= v_src_s;
         if (v_src_s) begin
            res_q[0] <= res_d;
            sat_q[0] <= sat_d;
         end
         for (int i = 1; i < NR; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               res_q[i] <= res_q[i-1];
               sat_q[i] <= sat_q[i-1];
            end
         end
      end
   end

   assign out_valid = vld_q[NR-1];
   assign dout      = res_q[NR-1];
   assign dout_sat  = sat_q[NR-1];

   eclair_mul_pipe_chk #(
      .DOUT_WIDTH (DOUT_WIDTH),
      .SATURATE   (SATURATE)
   ) u_chk (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .dout_sat  (dout_sat)
   );
endmodule

// File: tb/tb_eclair_mul_pipe.sv
// Bench for eclair_mul_pipe: three configurations (defaults, 16b shift/round/saturate,
// single-stage signed) checked by directed vectors and a scoreboard-backed random run.

module tb_eclair_mul_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        out_ready;
   logic [9:0]  din0;
   logic [15:0] din1;
   logic        iv [3];
   logic        ir0, ir1, ir2, ov0, ov1, ov2, sat0, sat1, sat2;
   logic [25:0] dout0, dout2;
   logic [15:0] dout1;
   logic        ir [3];
   logic        ov [3];
   logic        sv [3];
   logic [63:0] dv [3];

   eclair_mul_pipe u_dut0 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .din0(din0), .din1(din1), .out_valid(ov0), .out_ready(out_ready),
      .dout(dout0), .dout_sat(sat0));

   eclair_mul_pipe #(.DOUT_WIDTH(16), .SHIFT(4), .ROUND(1), .SATURATE(1)) u_dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .din0(din0), .din1(din1), .out_valid(ov1), .out_ready(out_ready),
      .dout(dout1), .dout_sat(sat1));

   eclair_mul_pipe #(.NUM_STAGE(1), .DIN0_SIGNED(1)) u_dut2 (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .din0(din0), .din1(din1), .out_valid(ov2), .out_ready(out_ready),
      .dout(dout2), .dout_sat(sat2));

   assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = ir2;
   assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
   assign sv[0] = sat0; assign sv[1] = sat1; assign sv[2] = sat2;
   assign dv[0] = {38'd0, dout0};
   assign dv[1] = {48'd0, dout1};
   assign dv[2] = {38'd0, dout2};

   typedef struct {
      int          d;
      logic [63:0] dout;
      logic        sat;
   } sb_t;

   typedef struct {
      int          d;
      logic [9:0]  a;
      logic [15:0] b;
      longint      e;
      logic        s;
      int          lat;
   } vec_t;

   sb_t sbq[$];
   int  checks = 0;
   int  errors = 0;
   int  n_out [3];
   int  n_stall [3];
   logic        prev_stall [3];
   logic [63:0] prev_d [3];
   logic        prev_s [3];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] dmask(input int d);
      return (d == 1) ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_03FF_FFFF;
   endfunction

   // Reference: plain integer arithmetic from each configuration's rules.
   function automatic void model(input int d, input logic [9:0] a, input logic [15:0] b,
                                 output logic [63:0] ed, output logic es);
      longint av, bv, p, q, mx, mn;
      int     sh, dw;
      bit     rnd, sat, s0;
      case (d)
         1:       begin s0 = 1'b0; sh = 4; dw = 16; rnd = 1'b1; sat = 1'b1; end
         2:       begin s0 = 1'b1; sh = 0; dw = 26; rnd = 1'b0; sat = 1'b0; end
         default: begin s0 = 1'b0; sh = 0; dw = 26; rnd = 1'b0; sat = 1'b0; end
      endcase
      if (s0) av = longint'($signed(a));
      else    av = longint'({54'd0, a});
      bv = longint'($signed(b));
      p  = av * bv;
      if (rnd && sh > 0) q = (p + (longint'(1) <<< (sh - 1))) >>> sh;
      else               q = p >>> sh;
      mx = (longint'(1) <<< (dw - 1)) - 1;
      mn = -mx - 1;
      es = 1'b0;
      if (sat && q > mx)      begin q = mx; es = 1'b1; end
      else if (sat && q < mn) begin q = mn; es = 1'b1; end
      ed = 64'(q) & dmask(d);
   endfunction

   // Output monitor / scoreboard, sampled on the falling edge.
   initial begin
      sb_t         e;
      logic [63:0] ed;
      logic        es;
      for (int d = 0; d < 3; d++) begin
         n_out[d] = 0; n_stall[d] = 0; prev_stall[d] = 1'b0;
         prev_d[d] = 64'd0; prev_s[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sbq.delete();
            for (int d = 0; d < 3; d++) prev_stall[d] = 1'b0;
         end else begin
            for (int d = 0; d < 3; d++) begin
               check($sformatf("in_ready_d%0d", d), 64'(ir[d]), 64'(!(ov[d] && !out_ready)));
               if (prev_stall[d]) begin
                  check($sformatf("hold_valid_d%0d", d), 64'(ov[d]), 64'd1);
                  check($sformatf("hold_dout_d%0d", d), dv[d], prev_d[d]);
                  check($sformatf("hold_sat_d%0d", d), 64'(sv[d]), 64'(prev_s[d]));
               end
               if (iv[d] && ir[d]) begin
                  model(d, din0, din1, ed, es);
                  e.d = d; e.dout = ed; e.sat = es;
                  sbq.push_back(e);
               end
               if (ov[d] && out_ready) begin
                  if (sbq.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_out_d%0d: got %0h expected none", d, dv[d]);
                  end else begin
                     e = sbq.pop_front();
                     check($sformatf("sb_dut_d%0d", d), 64'(d), 64'(e.d));
                     check($sformatf("sb_dout_d%0d", d), dv[d], e.dout);
                     check($sformatf("sb_sat_d%0d", d), 64'(sv[d]), 64'(e.sat));
                     n_out[d]++;
                  end
               end
               if (!ir[d]) n_stall[d]++;
               prev_stall[d] = ov[d] && !out_ready;
               prev_d[d]     = dv[d];
               prev_s[d]     = sv[d];
            end
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int lat;
      @(posedge clk); #1;
      din0 = v.a; din1 = v.b; iv[v.d] = 1'b1;
      @(posedge clk); #1;
      iv[v.d] = 1'b0;
      lat = 1;
      while (!ov[v.d] && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("vec_lat_d%0d", v.d), 64'(lat), 64'(v.lat));
      check($sformatf("vec_dout_d%0d_%0h_%0h", v.d, v.a, v.b), dv[v.d],
            64'(v.e) & dmask(v.d));
      check($sformatf("vec_sat_d%0d", v.d), 64'(sv[v.d]), 64'(v.s));
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int d, input logic [9:0] a, input logic [15:0] b,
                       output int tries);
      logic acc;
      din0 = a; din1 = b; iv[d] = 1'b1; tries = 0;
      do begin
         @(negedge clk);
         acc = ir[d];
         @(posedge clk); #1;
         tries++;
      end while (!acc && tries < 50);
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout_d%0d: got no accept expected accept", d);
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (sbq.size() != 0 && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_empty", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tv [12];
      int   t, tsum, n0, ns0;
      logic seen, acc;

      rst_n = 1'b0; out_ready = 1'b1; din0 = 10'd0; din1 = 16'd0;
      for (int d = 0; d < 3; d++) iv[d] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_valid_d%0d", d), 64'(ov[d]), 64'd0);
         check($sformatf("rst_dout_d%0d", d), dv[d], 64'd0);
         check($sformatf("rst_sat_d%0d", d), 64'(sv[d]), 64'd0);
         check($sformatf("rst_ready_d%0d", d), 64'(ir[d]), 64'd1);
      end
      rst_n = 1'b1;

      tv[0]  = '{0, 10'd1023, 16'h8000, -64'sd33521664, 1'b0, 2};
      tv[1]  = '{0, 10'd0,    16'd12345, 64'sd0,        1'b0, 2};
      tv[2]  = '{0, 10'd1023, 16'h7FFF,  64'sd33520641, 1'b0, 2};
      tv[3]  = '{1, 10'd1023, 16'h7FFF,  64'sd32767,    1'b1, 2};
      tv[4]  = '{1, 10'd3,    16'hFFFB, -64'sd1,        1'b0, 2};
      tv[5]  = '{1, 10'd1023, 16'h8000, -64'sd32768,    1'b1, 2};
      tv[6]  = '{1, 10'd100,  16'd100,   64'sd625,      1'b0, 2};
      tv[7]  = '{1, 10'd1,    16'd8,     64'sd1,        1'b0, 2};
      tv[8]  = '{1, 10'd1,    16'hFFF8,  64'sd0,        1'b0, 2};
      tv[9]  = '{2, 10'h200,  16'h8000,  64'sd16777216, 1'b0, 1};
      tv[10] = '{2, 10'h3FF,  16'd1,    -64'sd1,        1'b0, 1};
      tv[11] = '{2, 10'd511,  16'h7FFF,  64'sd16743937, 1'b0, 1};
      for (int i = 0; i < 12; i++) run_vec(tv[i]);
      drain();

      // Back-to-back stream: one accept per cycle, all results delivered.
      n0 = n_out[0];
      for (int i = 1; i <= 8; i++) begin
         send(0, 10'(i), 16'(-i), t);
         check("b2b_in_ready", 64'(t), 64'd1);
      end
      iv[0] = 1'b0;
      drain();
      check("b2b_count", 64'(n_out[0] - n0), 64'd8);

      // Same stream with a three-cycle downstream stall in the middle.
      n0 = n_out[0]; ns0 = n_stall[0]; tsum = 0;
      fork
         begin
            for (int i = 1; i <= 8; i++) begin
               send(0, 10'(i), 16'(-i), t);
               tsum += t;
            end
            iv[0] = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stall_count", 64'(n_out[0] - n0), 64'd8);
      check("stall_cycles", 64'(n_stall[0] - ns0), 64'd3);
      check("stall_tries", 64'(tsum), 64'd11);

      // Reset with two pairs in flight discards them.
      n0 = n_out[0];
      out_ready = 1'b0;
      send(0, 10'd5, 16'd7, t);
      send(0, 10'd6, 16'd7, t);
      iv[0] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_flight_valid", 64'(ov[0]), 64'd0);
      check("rst_flight_dout", dv[0], 64'd0);
      check("rst_flight_sat", 64'(sv[0]), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1; seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ov[0]) seen = 1'b1;
      end
      check("rst_no_ghost", 64'(seen), 64'd0);
      check("rst_no_out", 64'(n_out[0] - n0), 64'd0);

      // Randomized traffic with random backpressure on each configuration.
      for (int d = 0; d < 3; d++) begin
         n0 = n_out[d]; t = 0; acc = 1'b0;
         for (int c = 0; c < 4000 && t < 150; c++) begin
            @(posedge clk); #1;
            if (iv[d] && acc) begin t++; iv[d] = 1'b0; end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!iv[d] && t < 150 && $urandom_range(0, 2) != 0) begin
               din0 = 10'($urandom); din1 = 16'($urandom); iv[d] = 1'b1;
            end
            @(negedge clk);
            acc = ir[d];
         end
         @(posedge clk); #1;
         if (iv[d] && acc) t++;
         iv[d] = 1'b0; out_ready = 1'b1;
         drain();
         check($sformatf("rand_count_d%0d", d), 64'(n_out[d] - n0), 64'(t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
